// File: rtl/dmem_lsu_pkg.sv
// Shared constants, FSM encoding and legality check for the data-RAM load/store unit.
package dmem_lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      LOAD_CAP = 2'd2,
      RESP     = 2'd3
   } state_t;

   // Unsigned variants only exist for loads; natural alignment is required.
   function automatic logic is_legal(input logic [2:0] funct3, input logic we,
                                     input logic [1:0] off);
      logic ok;
      case (funct3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~off[0];
         F3_W:    ok = (off == 2'b00);
         F3_BU:   ok = ~we;
         F3_HU:   ok = ~we & ~off[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Store lane steering / byte-enable generation and load shift / extension.
module dmem_lsu_align
   import dmem_lsu_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_be,
   output logic [31:0] st_data,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] rd_data,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   always_comb begin
      st_be   = 4'b0000;
      st_data = st_wdata;
      case (st_funct3)
         F3_B: begin
            st_be   = 4'b0001 << st_off;
            st_data = {4{st_wdata[7:0]}};
         end
         F3_H: begin
            st_be   = st_off[1] ? 4'b1100 : 4'b0011;
            st_data = {2{st_wdata[15:0]}};
         end
         F3_W:    st_be = 4'b1111;
         default: st_be = 4'b0000;
      endcase
   end

   assign shifted = rd_data >> {ld_off, 3'b000};

   always_comb begin
      case (ld_funct3)
         F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   ld_data = {24'd0, shifted[7:0]};
         F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   ld_data = {16'd0, shifted[15:0]};
         default: ld_data = shifted;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a single-port byte-enabled RAM with a 1-cycle read.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   output logic                  mem_wr_en,
   output logic [BE_WIDTH-1:0]   mem_wr_byte_en,
   input  logic [DATA_WIDTH-1:0] mem_rd_data
);

   state_t      state, state_nxt;
   logic [1:0]  off_q;
   logic [2:0]  f3_q;
   logic        we_q;
   logic        accept, legal;
   logic [3:0]  st_be;
   logic [31:0] st_data, ld_data;
   logic        unused_addr;

   // Upper address bits are dropped so accesses wrap modulo the RAM size.
   assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];
   assign accept      = req_valid & req_ready;
   assign legal       = is_legal(req_funct3, req_we, req_addr[1:0]);

   dmem_lsu_align u_align (
      .st_funct3 (req_funct3),
      .st_off    (req_addr[1:0]),
      .st_wdata  (req_wdata),
      .st_be     (st_be),
      .st_data   (st_data),
      .ld_funct3 (f3_q),
      .ld_off    (off_q),
      .rd_data   (mem_rd_data),
      .ld_data   (ld_data)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (accept) state_nxt = legal ? ACCESS : RESP;
         ACCESS:   state_nxt = we_q ? RESP : LOAD_CAP;
         LOAD_CAP: state_nxt = RESP;
         RESP:     if (rsp_ready) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         off_q          <= '0;
         f3_q           <= '0;
         we_q           <= 1'b0;
         mem_addr       <= '0;
         mem_wr_data    <= '0;
         mem_wr_en      <= 1'b0;
         mem_wr_byte_en <= '0;
         rsp_valid      <= 1'b0;
         rsp_rdata      <= '0;
         rsp_err        <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               off_q <= req_addr[1:0];
               f3_q  <= req_funct3;
               we_q  <= req_we;
               if (legal) begin
                  mem_addr <= req_addr[ADDR_WIDTH+1:2];
                  if (req_we) begin
                     mem_wr_en      <= 1'b1;
                     mem_wr_byte_en <= st_be;
                     mem_wr_data    <= st_data;
                  end
               end else begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end
            end
            ACCESS: begin
               mem_wr_en      <= 1'b0;
               mem_wr_byte_en <= '0;
               if (we_q) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= '0;
               end
            end
            LOAD_CAP: begin
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_rdata <= ld_data;
            end
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized bench for dmem_lsu against a byte-array reference memory.
module tb_dmem_lsu;
   import dmem_lsu_pkg::*;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_we;
   logic [2:0]    req_funct3;
   logic [31:0]   req_addr, req_wdata;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [31:0]   rsp_rdata;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wr_data, mem_rd_data;
   logic          mem_wr_en;
   logic [3:0]    mem_wr_byte_en;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dmem_lsu #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .BE_WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
      .mem_wr_byte_en(mem_wr_byte_en), .mem_rd_data(mem_rd_data)
   );

   // 1-cycle-read byte-enabled RAM
   logic [31:0] ram [1024];
   always @(posedge clk) begin
      if (mem_wr_en)
         for (int b = 0; b < 4; b++)
            if (mem_wr_byte_en[b]) ram[mem_addr][8*b +: 8] <= mem_wr_data[8*b +: 8];
      mem_rd_data <= ram[mem_addr];
   end

   int          wr_pulses;
   logic [31:0] wr_addr_s;
   logic [3:0]  wr_be_s;
   always @(posedge clk) begin
      if (mem_wr_en) begin
         wr_pulses++;
         wr_addr_s = 32'(mem_addr);
         wr_be_s   = mem_wr_byte_en;
      end
   end

   // Reference memory: 4 KiB flat byte array
   logic [7:0] ref_mem [4096];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int acc_size(input logic [2:0] f3);
      return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
   endfunction

   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output bit err, output logic [31:0] rd,
                        output logic [3:0] be);
      int n, base;
      logic [31:0] mask;
      rd = 0; be = 0;
      err = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3[2]);
      n = acc_size(f3);
      if (!err && (int'(addr[1:0]) % n) != 0) err = 1;
      if (err) return;
      base = int'(addr[11:0]);
      if (we) begin
         for (int i = 0; i < n; i++) ref_mem[base + i] = wdata[8*i +: 8];
         be = 4'(((1 << n) - 1) << addr[1:0]);
      end else begin
         for (int i = 0; i < n; i++) rd[8*i +: 8] = ref_mem[base + i];
         if (!f3[2] && n < 4 && rd[8*n - 1]) begin
            mask = (32'h1 << (8*n)) - 32'h1;
            rd = rd | ~mask;
         end
      end
   endtask

   task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold);
      bit          e_err;
      logic [31:0] e_rd, s_rd;
      logic [3:0]  e_be;
      logic        s_err;
      int          edges, e_lat;
      model(we, f3, addr, wdata, e_err, e_rd, e_be);
      e_lat = e_err ? 1 : (we ? 2 : 3);
      @(negedge clk);
      wr_pulses  = 0;
      req_valid  = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      rsp_ready  = 1'b0;
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      edges = 1;
      while (!rsp_valid && edges < 8) begin
         @(posedge clk); #1;
         edges++;
      end
      chk("latency", edges, e_lat);
      chk("rsp_err", 32'(rsp_err), 32'(e_err));
      chk("rsp_rdata", rsp_rdata, e_rd);
      chk("wr_pulses", wr_pulses, (we && !e_err) ? 1 : 0);
      if (we && !e_err) begin
         chk("wr_addr", wr_addr_s, 32'(addr[AW+1:2]));
         chk("wr_be", 32'(wr_be_s), 32'(e_be));
      end
      s_rd = rsp_rdata; s_err = rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_rdata", rsp_rdata, s_rd);
         chk("hold_err", 32'(rsp_err), 32'(s_err));
         chk("hold_ready", 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("rel_valid", 32'(rsp_valid), 32'd0);
      chk("rel_ready", 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [2:0]  f3tab [8];
      logic [2:0]  f3;
      logic [31:0] a, w;
      f3tab = '{F3_B, F3_H, F3_W, F3_BU, F3_HU, F3_B, F3_H, F3_W};
      for (int i = 0; i < 1024; i++) begin
         ram[i] = $urandom;
         for (int b = 0; b < 4; b++) ref_mem[4*i + b] = ram[i][8*b +: 8];
      end
      rst = 1'b1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
      rsp_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_be", 32'(mem_wr_byte_en), 32'd0);
      chk("rst_wr_data", mem_wr_data, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);

      xact(1, F3_W, 32'h10, 32'hDEADBEEF, 0);
      xact(0, F3_W, 32'h10, 32'h0, 0);
      xact(1, F3_W, 32'h10, 32'h11223344, 0);
      xact(1, F3_B, 32'h13, 32'h000000A5, 0);
      xact(0, F3_W, 32'h10, 32'h0, 0);
      xact(0, F3_B, 32'h13, 32'h0, 0);
      xact(0, F3_BU, 32'h13, 32'h0, 0);
      xact(1, F3_H, 32'h22, 32'h00008001, 0);
      xact(0, F3_H, 32'h22, 32'h0, 0);
      xact(0, F3_HU, 32'h22, 32'h0, 0);
      xact(0, F3_W, 32'h06, 32'h0, 0);
      xact(1, F3_H, 32'h05, 32'hFFFF, 0);
      xact(0, F3_W, 32'h10, 32'h0, 5);

      // Reset while a load sits in LOAD_CAP
      @(negedge clk);
      req_valid = 1; req_we = 0; req_funct3 = F3_W; req_addr = 32'h10;
      @(posedge clk); #1;
      req_valid = 0;
      @(posedge clk); #1;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_rdata", rsp_rdata, 32'd0);
      chk("midrst_wr_en", 32'(mem_wr_en), 32'd0);
      chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
      chk("midrst_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk); rst = 1'b0;

      xact(1, F3_W, 32'h1000, 32'hCAFEF00D, 0);
      xact(0, F3_W, 32'h0, 32'h0, 0);

      for (int k = 0; k < 300; k++) begin
         int r;
         r  = $urandom_range(0, 9);
         f3 = (r < 8) ? f3tab[r] : 3'($urandom);
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & ~32'(acc_size(f3) - 1);
         w  = $urandom;
         xact(1'($urandom_range(0, 1)), f3, a, w, $urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
